rs_calc: RTL and testbench
==========================

Name: rs_calc

Overview:
- Upstream producer of the relative-strength value `uq8_8_t` consumed by the RSI stage.
- Takes a stream of prices and computes per-sample gain and loss.
- Maintains Wilder-style smoothed average gain and average loss.
- Computes RS = avg_gain / avg_loss in uq8.8 with a multi-cycle sequential divider.
- Emits one RS result per accepted price once warm-up is complete.

Parameters:
- G_SHIFT, 4: smoothing shift. Period N = 2^G_SHIFT. Legal range 1..6.
- G_DIV_ITERS, 24: divider iterations. Fixed at quotient width; not user-tunable.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset. Asynchronous, active-low.
- i_price  in  16  price, `uq8_8_t`.
- i_price_valid  in  1  price strobe. Accepted only when o_ready=1.
- o_ready  out  1  block idle and able to accept a price.
- o_rs_scaled  out  16  RS, `uq8_8_t`.
- o_rs_valid  out  1  one-cycle pulse; o_rs_scaled is new.
- o_drop  out  1  one-cycle pulse; a price arrived while o_ready=0 and was discarded.

Behaviour:
- Reset (i_rst=0, async): all state cleared, FSM=IDLE. Outputs: o_ready=1, o_rs_scaled=0x0000, o_rs_valid=0, o_drop=0.
- Reset mid-division aborts the division; no result is emitted.
- FSM states and transitions:
  - IDLE: accept on i_price_valid & o_ready, then go to UPD.
  - UPD: one cycle. Goes to DIV if seeded, otherwise back to IDLE.
  - DIV: G_DIV_ITERS cycles, then DONE.
  - DONE: one cycle, o_rs_valid=1, then IDLE.
- o_ready = (state==IDLE).
- Warm-up:
  - The first accepted price after reset only loads prev_price.
  - The next N accepted prices each produce a delta. Gain and loss are summed into 22-bit accumulators.
  - On the Nth delta (in UPD): avg_gain = sum_gain >> G_SHIFT, avg_loss = sum_loss >> G_SHIFT; seeded flag set; the division starts.
  - Earlier warm-up samples return to IDLE with no output.
- Per-sample arithmetic:
  - delta = price − prev_price, 17-bit signed.
  - gain = delta>0 ? delta : 0; loss = delta<0 ? −delta : 0.
  - prev_price ← price on every accept.
- Seeded update, 17-bit signed intermediate, result truncated to 16 bits, never negative:
  - avg_gain += (gain − avg_gain) >>> G_SHIFT.
  - avg_loss += (loss − avg_loss) >>> G_SHIFT.
- Division:
  - Numerator = {avg_gain, 8'h00} (24 bits); divisor = avg_loss.
  - Unsigned restoring division, one quotient bit per cycle.
  - Operands are latched at DIV entry, so later state changes cannot corrupt a running division.
- Special cases, resolved in UPD (still pass through DIV so latency stays constant):
  - avg_loss=0 and avg_gain>0: RS=0xFFFF.
  - avg_loss=0 and avg_gain=0: RS=0x0100 (1.0, i.e. RSI 50).
  - Quotient[23:16]≠0: saturate to 0xFFFF.
- Latency:
  - Accept edge = edge 0. o_rs_valid is registered high after edge G_DIV_ITERS+2 (26 at default) for exactly one cycle.
  - o_ready returns to 1 on the following edge.
  - Throughput: one result per G_DIV_ITERS+3 cycles.
- o_rs_scaled holds its value between results.
- i_price_valid while o_ready=0:
  - The sample is discarded and o_drop pulses one cycle.
  - State and the running division are unaffected.

Optional Feature:
- Macro RS_CALC_SAT_FLAG_EN.
- Defined: adds output port o_rs_sat (1 bit), registered alongside o_rs_valid. It is 1 when the emitted RS was forced to 0xFFFF (avg_loss=0 with gain>0, or overflow), and holds its value until the next result. Reset value 0.
- Undefined: port absent; saturation behaviour is otherwise identical.

Decomposition:
- Shared package fixed_pkg gains:
  - `uq16_8_t` (24-bit unsigned numerator type).
  - `sq9_8_t` (17-bit signed delta type).
  - Constants `UQ8_8_MAX`=16'hFFFF and `ONE_Q8`=16'h0100.
- Natural sub-module: seq_divider.
  - Parameterised unsigned restoring divider.
  - Interface: start/busy/done handshake, 24-bit numerator, 16-bit divisor, 24-bit quotient.
  - Reused by later indicator blocks.

Test Plan:
- Common setup: G_SHIFT=2.
- Basic RS:
  - Stimulus: prices 0x0A00, 0x0B00, 0x0A80, 0x0B80, 0x0B00.
  - Response: exactly one o_rs_valid, after the 5th accept, with o_rs_scaled=0x0200 (avg_gain=0x0080, avg_loss=0x0040).
- All-rising:
  - Stimulus: prices 0x0100, 0x0200, 0x0300, 0x0400, 0x0500.
  - Response: o_rs_scaled=0xFFFF; o_rs_sat=1 when RS_CALC_SAT_FLAG_EN is defined.
- Flat:
  - Stimulus: five prices of 0x0500.
  - Response: o_rs_scaled=0x0100.
- Latency / drop:
  - Stimulus: after seeding, one accepted price, then i_price_valid asserted 5 cycles later.
  - Response: o_drop pulses once; o_rs_valid appears exactly 26 edges after the accept; the result ignores the dropped price.
- Reset mid-DIV:
  - Stimulus: i_rst=0 for 1 cycle at DIV cycle 10.
  - Response: no o_rs_valid; o_ready=1 and o_rs_scaled=0 immediately (async); re-warm-up needs 5 prices before the next output.
- Smoothing:
  - Stimulus: continue the basic-RS sequence with price 0x0B80.
  - Response: avg_gain=0x0080, avg_loss=0x0030, o_rs_scaled=0x02AA.

Source files
------------

// File: rtl/fixed_pkg.sv
// Fixed-point types and constants shared by the indicator datapaths.
// uq8_8_t  : 16-bit unsigned Q8.8 (prices, averages, RS)
// uq16_8_t : 24-bit unsigned Q16.8 (divider numerator / quotient)
// sq9_8_t  : 17-bit signed Q9.8 (price deltas, smoothing steps)
package fixed_pkg;

  localparam int unsigned UQ8_8_W  = 16;
  localparam int unsigned UQ16_8_W = 24;
  localparam int unsigned SQ9_8_W  = 17;
  localparam int unsigned ACC_W    = 22;

  typedef logic        [UQ8_8_W-1:0]  uq8_8_t;
  typedef logic        [UQ16_8_W-1:0] uq16_8_t;
  typedef logic signed [SQ9_8_W-1:0]  sq9_8_t;
  typedef logic        [ACC_W-1:0]    acc_t;

  localparam uq8_8_t UQ8_8_MAX = 16'hFFFF;
  localparam uq8_8_t ONE_Q8    = 16'h0100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPD,
    ST_DIV,
    ST_DONE
  } rs_state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (async active-low), start (sampled when idle),
//        num/den operands (latched on start), busy (iterating),
//        done (one-cycle pulse with quo valid), quo (quotient, held).
// A zero divisor yields an all-ones quotient; callers treat it as special.
module seq_divider #(
  parameter int unsigned NUM_W = 24,
  parameter int unsigned DEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quo
);

  localparam int unsigned CNT_W = $clog2(NUM_W + 1);

  logic [CNT_W-1:0] cnt;
  logic [DEN_W-1:0] rem;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W:0]   rem_sh;
  logic [DEN_W-1:0] rem_sub;
  logic             fits;

  // Shift in the next dividend bit; the difference fits DEN_W bits whenever it is kept.
  always_comb begin
    rem_sh  = {rem, quo[NUM_W-1]};
    rem_sub = rem_sh[DEN_W-1:0] - den_q;
    fits    = (rem_sh >= {1'b0, den_q});
  end

  // quo doubles as the dividend shift register while iterating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem   <= '0;
      den_q <= '0;
      quo   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        cnt   <= CNT_W'(NUM_W);
        rem   <= '0;
        den_q <= den;
        quo   <= num;
        busy  <= 1'b1;
      end else if (busy) begin
        rem <= fits ? rem_sub : rem_sh[DEN_W-1:0];
        quo <= {quo[NUM_W-2:0], fits};
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rs_calc.sv
// Relative-strength calculator: Wilder-smoothed average gain / average loss
// of a price stream, emitted as uq8.8 RS once warm-up is complete.
// Ports: i_clk, i_rst (async active-low), i_price/i_price_valid (input
//        sample, taken only when o_ready), o_ready (idle), o_rs_scaled
//        (RS, held between results), o_rs_valid (result pulse),
//        o_drop (sample arrived while busy and was discarded).
// Optional macro RS_CALC_SAT_FLAG_EN adds o_rs_sat: the emitted RS was
// forced to full scale (zero loss with gain, or quotient overflow).
module rs_calc
  import fixed_pkg::*;
#(
  parameter int unsigned G_SHIFT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [UQ8_8_W-1:0] i_price,
  input  logic               i_price_valid,
  output logic               o_ready,
  output logic [UQ8_8_W-1:0] o_rs_scaled,
  output logic               o_rs_valid,
  output logic               o_drop
`ifdef RS_CALC_SAT_FLAG_EN
  ,
  output logic               o_rs_sat
`endif
);

  localparam int unsigned G_DIV_ITERS = UQ16_8_W;
  localparam int unsigned N           = 1 << G_SHIFT;
  localparam int unsigned WARM_W      = 7;

  rs_state_e          state, state_next;
  uq8_8_t             prev_price, prev_price_next;
  logic               have_prev, have_prev_next;
  logic               delta_ok, delta_ok_next;
  uq8_8_t             gain, gain_next, loss, loss_next;
  acc_t               sum_gain, sum_gain_next, sum_loss, sum_loss_next;
  logic [WARM_W-1:0]  warm_cnt, warm_cnt_next;
  uq8_8_t             avg_gain, avg_gain_next, avg_loss, avg_loss_next;
  logic               seeded, seeded_next;
  logic               sp_flag, sp_flag_next, sp_max, sp_max_next;
  uq8_8_t             rs_next;
  logic               ready_next, rs_valid_next, drop_next;
  logic               forced;
  sq9_8_t             delta, step_gain, step_loss;
  acc_t               sg_acc, sl_acc;
  uq16_8_t            div_num, div_quo;
  logic               div_start, div_busy, div_done;

  // Next-state, datapath and output decode.
  always_comb begin
    state_next      = state;
    prev_price_next = prev_price;
    have_prev_next  = have_prev;
    delta_ok_next   = delta_ok;
    gain_next       = gain;
    loss_next       = loss;
    sum_gain_next   = sum_gain;
    sum_loss_next   = sum_loss;
    warm_cnt_next   = warm_cnt;
    avg_gain_next   = avg_gain;
    avg_loss_next   = avg_loss;
    seeded_next     = seeded;
    sp_flag_next    = sp_flag;
    sp_max_next     = sp_max;
    rs_next         = o_rs_scaled;
    div_start       = 1'b0;

    delta     = sq9_8_t'({1'b0, i_price}) - sq9_8_t'({1'b0, prev_price});
    sg_acc    = sum_gain + ACC_W'(gain);
    sl_acc    = sum_loss + ACC_W'(loss);
    step_gain = (sq9_8_t'({1'b0, gain}) - sq9_8_t'({1'b0, avg_gain})) >>> G_SHIFT;
    step_loss = (sq9_8_t'({1'b0, loss}) - sq9_8_t'({1'b0, avg_loss})) >>> G_SHIFT;
    // Full-scale result: zero-loss-with-gain decided in UPD, else quotient overflow.
    forced    = sp_flag ? sp_max : (div_quo[UQ16_8_W-1:UQ8_8_W] != '0);

    case (state)
      ST_IDLE: begin
        if (i_price_valid) begin
          prev_price_next = i_price;
          have_prev_next  = 1'b1;
          delta_ok_next   = have_prev;
          gain_next       = (!delta[SQ9_8_W-1] && (delta != '0)) ? UQ8_8_W'(delta) : '0;
          loss_next       = delta[SQ9_8_W-1] ? UQ8_8_W'(-delta) : '0;
          state_next      = ST_UPD;
        end
      end
      ST_UPD: begin
        state_next = ST_IDLE;
        if (delta_ok) begin
          if (!seeded) begin
            sum_gain_next = sg_acc;
            sum_loss_next = sl_acc;
            warm_cnt_next = warm_cnt + WARM_W'(1);
            if (warm_cnt == WARM_W'(N - 1)) begin
              avg_gain_next = UQ8_8_W'(sg_acc >> G_SHIFT);
              avg_loss_next = UQ8_8_W'(sl_acc >> G_SHIFT);
              seeded_next   = 1'b1;
              state_next    = ST_DIV;
            end
          end else begin
            // Averages cannot go negative: the floored step never exceeds the current average.
            avg_gain_next = UQ8_8_W'(sq9_8_t'({1'b0, avg_gain}) + step_gain);
            avg_loss_next = UQ8_8_W'(sq9_8_t'({1'b0, avg_loss}) + step_loss);
            state_next    = ST_DIV;
          end
        end
        if (state_next == ST_DIV) begin
          div_start    = !div_busy;
          sp_flag_next = (avg_loss_next == '0);
          sp_max_next  = (avg_gain_next != '0);
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_next = ST_DONE;
          rs_next    = forced ? UQ8_8_MAX : (sp_flag ? ONE_Q8 : div_quo[UQ8_8_W-1:0]);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    div_num       = {avg_gain_next, 8'h00};
    ready_next    = (state_next == ST_IDLE);
    rs_valid_next = (state_next == ST_DONE);
    drop_next     = i_price_valid && (state != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= ST_IDLE;
      prev_price  <= '0;
      have_prev   <= 1'b0;
      delta_ok    <= 1'b0;
      gain        <= '0;
      loss        <= '0;
      sum_gain    <= '0;
      sum_loss    <= '0;
      warm_cnt    <= '0;
      avg_gain    <= '0;
      avg_loss    <= '0;
      seeded      <= 1'b0;
      sp_flag     <= 1'b0;
      sp_max      <= 1'b0;
      o_ready     <= 1'b1;
      o_rs_scaled <= '0;
      o_rs_valid  <= 1'b0;
      o_drop      <= 1'b0;
    end else begin
      state       <= state_next;
      prev_price  <= prev_price_next;
      have_prev   <= have_prev_next;
      delta_ok    <= delta_ok_next;
      gain        <= gain_next;
      loss        <= loss_next;
      sum_gain    <= sum_gain_next;
      sum_loss    <= sum_loss_next;
      warm_cnt    <= warm_cnt_next;
      avg_gain    <= avg_gain_next;
      avg_loss    <= avg_loss_next;
      seeded      <= seeded_next;
      sp_flag     <= sp_flag_next;
      sp_max      <= sp_max_next;
      o_ready     <= ready_next;
      o_rs_scaled <= rs_next;
      o_rs_valid  <= rs_valid_next;
      o_drop      <= drop_next;
    end
  end

`ifdef RS_CALC_SAT_FLAG_EN
  // Saturation flag updates only with a new result.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rs_sat <= 1'b0;
    end else if (state == ST_DIV && div_done) begin
      o_rs_sat <= forced;
    end
  end
`endif

  seq_divider #(
    .NUM_W (G_DIV_ITERS),
    .DEN_W (UQ8_8_W)
  ) u_div (
    .clk   (i_clk),
    .rst_n (i_rst),
    .start (div_start),
    .num   (div_num),
    .den   (avg_loss_next),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

endmodule

// File: tb/tb_rs_calc.sv
// Self-checking bench for rs_calc (G_SHIFT=2): directed scenarios plus a
// randomized price stream, all checked every cycle against a behavioural model.
module tb_rs_calc;

  localparam int GS      = 2;
  localparam int NP      = 1 << GS;
  localparam int LAT     = 26;
  localparam int BUSY    = 27;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [15:0] i_price = '0;
  logic        i_price_valid = 1'b0;
  logic        o_ready, o_rs_valid, o_drop;
  logic [15:0] o_rs_scaled;
`ifdef RS_CALC_SAT_FLAG_EN
  logic        o_rs_sat;
`endif

  int total = 0;
  int bad   = 0;

  rs_calc #(.G_SHIFT(GS)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_price       (i_price),
    .i_price_valid (i_price_valid),
    .o_ready       (o_ready),
    .o_rs_scaled   (o_rs_scaled),
    .o_rs_valid    (o_rs_valid),
    .o_drop        (o_drop)
`ifdef RS_CALC_SAT_FLAG_EN
    ,
    .o_rs_sat      (o_rs_sat)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  e = 0;
  bit  m_have_prev = 0, m_seeded = 0;
  int  m_prev = 0, m_nd = 0, m_sg = 0, m_sl = 0, m_ag = 0, m_al = 0;
  int  ready_edge = 0, valid_edge = -1;
  bit  m_ready = 1, exp_valid = 0, exp_drop = 0, exp_sat = 0, pend_sat = 0;
  int  exp_rs = 0, pend_rs = 0;

  task automatic model_reset();
    m_have_prev = 0; m_seeded = 0;
    m_prev = 0; m_nd = 0; m_sg = 0; m_sl = 0; m_ag = 0; m_al = 0;
    ready_edge = 0; valid_edge = -1;
    m_ready = 1; exp_valid = 0; exp_drop = 0; exp_rs = 0; exp_sat = 0;
  endtask

  function automatic int floor_div(input int x);
    if (x >= 0) return x / NP;
    return -((-x + NP - 1) / NP);
  endfunction

  task automatic model_accept(input int p, output bit out);
    int d, g, l;
    out = 0;
    if (!m_have_prev) begin
      m_have_prev = 1;
      m_prev = p;
    end else begin
      d = p - m_prev;
      m_prev = p;
      g = (d > 0) ? d : 0;
      l = (d < 0) ? -d : 0;
      if (!m_seeded) begin
        m_sg += g; m_sl += l; m_nd++;
        if (m_nd == NP) begin
          m_ag = m_sg / NP; m_al = m_sl / NP; m_seeded = 1; out = 1;
        end
      end else begin
        m_ag = (m_ag + floor_div(g - m_ag)) % 65536;
        m_al = (m_al + floor_div(l - m_al)) % 65536;
        out = 1;
      end
    end
  endtask

  task automatic rs_of(input int ag, input int al, output int rs, output bit sat);
    longint q;
    if (al == 0) begin
      sat = (ag > 0);
      rs  = sat ? 'hFFFF : 'h0100;
    end else begin
      q   = longint'(ag) * 256 / al;
      sat = (q > 'hFFFF);
      rs  = sat ? 'hFFFF : int'(q);
    end
  endtask

  always @(posedge i_clk) begin : model_step
    bit out;
    e++;
    if (!i_rst) begin
      model_reset();
    end else begin
      exp_valid = (e == valid_edge);
      if (exp_valid) begin
        exp_rs  = pend_rs;
        exp_sat = pend_sat;
      end
      exp_drop = i_price_valid && !m_ready;
      if (i_price_valid && m_ready) begin
        model_accept(int'(i_price), out);
        ready_edge = e + (out ? BUSY : 1);
        if (out) begin
          valid_edge = e + LAT;
          rs_of(m_ag, m_al, pend_rs, pend_sat);
        end
      end
      m_ready = (e >= ready_edge);
    end
  end

  always @(negedge i_rst) model_reset();

  // ---------------- per-cycle compare ----------------
  always @(negedge i_clk) begin
    #2;
    check("ready",     32'(o_ready),     32'(m_ready));
    check("rs_valid",  32'(o_rs_valid),  32'(exp_valid));
    check("drop",      32'(o_drop),      32'(exp_drop));
    check("rs_scaled", 32'(o_rs_scaled), exp_rs);
`ifdef RS_CALC_SAT_FLAG_EN
    check("rs_sat",    32'(o_rs_sat),    32'(exp_sat));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic send_price(input int p);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("ready_wait", 32'(o_ready), 1);
    i_price = 16'(p);
    i_price_valid = 1'b1;
    @(negedge i_clk);
    i_price_valid = 1'b0;
  endtask

  task automatic wait_result(output int c);
    c = 0;
    while (o_rs_valid !== 1'b1 && c < 60) begin
      @(negedge i_clk);
      c++;
    end
    check("result_seen", 32'(o_rs_valid), 1);
  endtask

  task automatic pulse_reset();
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  initial begin
    int c, drops, valids, p;
    int basic[5] = '{'h0A00, 'h0B00, 'h0A80, 'h0B80, 'h0B00};

    repeat (3) @(negedge i_clk);
    check("reset_ready", 32'(o_ready), 1);
    check("reset_rs", 32'(o_rs_scaled), 0);
    i_rst = 1'b1;

    // Basic RS after warm-up
    foreach (basic[i]) send_price(basic[i]);
    wait_result(c);
    check("basic_latency", c, LAT);
    check("basic_rs", 32'(o_rs_scaled), 'h0200);
    check("basic_model_ag", m_ag, 'h0080);
    check("basic_model_al", m_al, 'h0040);

    // Smoothing step
    send_price('h0B80);
    wait_result(c);
    check("smooth_rs", 32'(o_rs_scaled), 'h02AA);
    check("smooth_model_ag", m_ag, 'h0080);
    check("smooth_model_al", m_al, 'h0030);

    // Latency with a dropped sample mid-division
    send_price('h0B00);
    c = 0;
    drops = 0;
    while (o_rs_valid !== 1'b1 && c < 60) begin
      if (c == 5) begin
        i_price = 16'h0000;
        i_price_valid = 1'b1;
      end else begin
        i_price_valid = 1'b0;
      end
      @(negedge i_clk);
      c++;
      if (o_drop === 1'b1) drops++;
    end
    i_price_valid = 1'b0;
    check("drop_latency", c, LAT);
    check("drop_count", drops, 1);
    check("drop_rs", 32'(o_rs_scaled), 'h0169);

    // Reset in the middle of a division
    send_price('h0C00);
    repeat (11) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_async_ready", 32'(o_ready), 1);
    check("rst_async_rs", 32'(o_rs_scaled), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    valids = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_rs_valid === 1'b1) valids++;
    end
    check("rst_no_result", valids, 0);

    // Re-warm-up with rising prices: four samples stay silent, fifth saturates
    for (int i = 1; i <= 4; i++) send_price(i * 'h100);
    valids = 0;
    repeat (30) begin
      @(negedge i_clk);
      if (o_rs_valid === 1'b1) valids++;
    end
    check("rewarm_silent", valids, 0);
    send_price('h0500);
    wait_result(c);
    check("rising_rs", 32'(o_rs_scaled), 'hFFFF);
`ifdef RS_CALC_SAT_FLAG_EN
    check("rising_sat", 32'(o_rs_sat), 1);
`endif

    // Flat prices
    pulse_reset();
    repeat (5) send_price('h0500);
    wait_result(c);
    check("flat_rs", 32'(o_rs_scaled), 'h0100);
`ifdef RS_CALC_SAT_FLAG_EN
    check("flat_sat", 32'(o_rs_sat), 0);
`endif

    // Random price walk with back-to-back strobes (many drops)
    pulse_reset();
    p = 'h4000;
    repeat (3000) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 15) == 0) p = int'($urandom_range(0, 'hFFFF));
        else p = p + int'($urandom_range(0, 'h300)) - 'h180;
        p = p & 'hFFFF;
        i_price = 16'(p);
        i_price_valid = 1'b1;
      end else begin
        i_price_valid = 1'b0;
      end
      @(negedge i_clk);
    end
    i_price_valid = 1'b0;
    repeat (40) @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
